// File: rtl/fp_normalize_round.sv
// fp_normalize_round: normalize-and-round-decision stage feeding fp_result_assembler
// Inputs : i_clk, i_rst_n (async, active-low), i_valid/o_ready, i_flush, i_mantissa_raw
//          (bit RawBits-2 = 2^0, bit RawBits-1 = carry), i_exp (signed biased exponent of 2^0),
//          i_sign, i_rm, special/zero metadata.
// Outputs: o_valid/i_ready, o_exp_work, o_mantissa_work, o_round_up, o_is_inexact,
//          o_is_zero_result, registered metadata copies.
// Config : FP_NORM_ROUND_SINGLE_CYCLE_EN drops the capture stage (latency 1, same results).
module fp_normalize_round #(
    parameter int FP_WIDTH   = 32,
    parameter int ExpBits    = 8,
    parameter int FracBits   = 23,
    parameter int MantBits   = FracBits + 1,
    parameter int ExpExtBits = ExpBits + 2,
    parameter int RawBits    = 2 * MantBits
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic                         i_flush,
    input  logic [RawBits-1:0]           i_mantissa_raw,
    input  logic signed [ExpExtBits-1:0] i_exp,
    input  logic                         i_sign,
    input  logic [2:0]                   i_rm,
    input  logic                         i_is_special,
    input  logic [FP_WIDTH-1:0]          i_special_result,
    input  logic                         i_special_invalid,
    input  logic                         i_special_div_zero,
    input  logic                         i_zero_sign,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic signed [ExpExtBits-1:0] o_exp_work,
    output logic [MantBits-1:0]          o_mantissa_work,
    output logic                         o_round_up,
    output logic                         o_is_inexact,
    output logic                         o_is_zero_result,
    output logic                         o_result_sign,
    output logic [2:0]                   o_rm,
    output logic                         o_is_special,
    output logic [FP_WIDTH-1:0]          o_special_result,
    output logic                         o_special_invalid,
    output logic                         o_special_div_zero,
    output logic                         o_zero_sign
);
    localparam int LzcW     = $clog2(RawBits + 1);
    localparam int ShMax    = MantBits + 2;
    localparam int ShW      = $clog2(ShMax + 1);
    localparam int GuardBit = RawBits - 1 - MantBits;
    localparam logic [2:0] RmRtz = 3'd1;
    localparam logic [2:0] RmRdn = 3'd2;
    localparam logic [2:0] RmRup = 3'd3;
    localparam logic [2:0] RmRmm = 3'd4;

    logic [LzcW-1:0] lzc_in;
    logic adv2;

    // Operands as seen by the normalize/round logic (capture registers or raw inputs)
    logic                         s_valid;
    logic [RawBits-1:0]           s_raw;
    logic signed [ExpExtBits-1:0] s_exp;
    logic [LzcW-1:0]              s_lzc;
    logic                         s_zero;
    logic                         s_sign;
    logic [2:0]                   s_rm;
    logic                         s_special;
    logic [FP_WIDTH-1:0]          s_sres;
    logic                         s_inv;
    logic                         s_dz;
    logic                         s_zs;

    always_comb begin
        lzc_in = LzcW'(RawBits);
        for (int i = 0; i < RawBits; i++)
            if (i_mantissa_raw[i]) lzc_in = LzcW'(RawBits - 1 - i);
    end

    assign adv2 = !o_valid | i_ready;

`ifdef FP_NORM_ROUND_SINGLE_CYCLE_EN
    assign o_ready = adv2;

    always_comb begin
        s_valid   = i_valid;
        s_raw     = i_mantissa_raw;
        s_exp     = i_exp;
        s_lzc     = lzc_in;
        s_zero    = (i_mantissa_raw == '0);
        s_sign    = i_sign;
        s_rm      = i_rm;
        s_special = i_is_special;
        s_sres    = i_special_result;
        s_inv     = i_special_invalid;
        s_dz      = i_special_div_zero;
        s_zs      = i_zero_sign;
    end
`else
    logic adv1;

    assign adv1    = !s_valid | adv2;
    assign o_ready = adv1;

    // Flush wins over a simultaneous capture, so an op accepted while flushing is dropped
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) s_valid <= 1'b0;
        else if (i_flush) s_valid <= 1'b0;
        else if (adv1) s_valid <= i_valid;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s_raw     <= '0;
            s_exp     <= '0;
            s_lzc     <= '0;
            s_zero    <= 1'b0;
            s_sign    <= 1'b0;
            s_rm      <= '0;
            s_special <= 1'b0;
            s_sres    <= '0;
            s_inv     <= 1'b0;
            s_dz      <= 1'b0;
            s_zs      <= 1'b0;
        end else if (adv1 && i_valid) begin
            s_raw     <= i_mantissa_raw;
            s_exp     <= i_exp;
            s_lzc     <= lzc_in;
            s_zero    <= (i_mantissa_raw == '0);
            s_sign    <= i_sign;
            s_rm      <= i_rm;
            s_special <= i_is_special;
            s_sres    <= i_special_result;
            s_inv     <= i_special_invalid;
            s_dz      <= i_special_div_zero;
            s_zs      <= i_zero_sign;
        end
    end
`endif

    logic [RawBits-1:0]           norm;
    logic [RawBits-1:0]           work;
    logic signed [ExpExtBits:0]   e_full;
    logic signed [ExpExtBits-1:0] e_sat;
    logic [ExpExtBits:0]          sh_full;
    logic [ShW-1:0]               sh;
    logic [MantBits-1:0]          mant;
    logic                         denorm;
    logic                         lost;
    logic                         g;
    logic                         s;
    logic                         rnd;

    // The left shift puts the leading one at the carry position, hence the +1 on the exponent.
    // Subnormals are shifted back right; clamping at MantBits+2 already empties mantissa and guard.
    always_comb begin
        norm    = s_raw << s_lzc;
        e_full  = {s_exp[ExpExtBits-1], s_exp} + (ExpExtBits+1)'(1) - (ExpExtBits+1)'(s_lzc);
        e_sat   = (e_full[ExpExtBits] == e_full[ExpExtBits-1]) ? e_full[ExpExtBits-1:0]
                : {e_full[ExpExtBits], {(ExpExtBits-1){~e_full[ExpExtBits]}}};
        denorm  = e_sat[ExpExtBits-1] | (e_sat == '0);
        sh_full = (ExpExtBits+1)'(1) - {e_sat[ExpExtBits-1], e_sat};
        sh      = (sh_full > (ExpExtBits+1)'(ShMax)) ? ShW'(ShMax) : sh_full[ShW-1:0];
        lost    = denorm & |(norm & ~({RawBits{1'b1}} << sh));
        work    = denorm ? norm >> sh : norm;
        mant    = work[RawBits-1 -: MantBits];
        g       = work[GuardBit];
        s       = |work[GuardBit-1:0] | lost;
        rnd     = (s_rm == RmRtz) ? 1'b0
                : (s_rm == RmRdn) ? (g | s) & s_sign
                : (s_rm == RmRup) ? (g | s) & ~s_sign
                : (s_rm == RmRmm) ? g
                : g & (s | mant[0]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_valid <= 1'b0;
        else if (i_flush) o_valid <= 1'b0;
        else if (adv2) o_valid <= s_valid;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_exp_work         <= '0;
            o_mantissa_work    <= '0;
            o_round_up         <= 1'b0;
            o_is_inexact       <= 1'b0;
            o_is_zero_result   <= 1'b0;
            o_result_sign      <= 1'b0;
            o_rm               <= '0;
            o_is_special       <= 1'b0;
            o_special_result   <= '0;
            o_special_invalid  <= 1'b0;
            o_special_div_zero <= 1'b0;
            o_zero_sign        <= 1'b0;
        end else if (adv2 && s_valid) begin
            o_exp_work         <= (s_special | s_zero | denorm) ? '0 : e_sat;
            o_mantissa_work    <= (s_special | s_zero) ? '0 : mant;
            o_round_up         <= !s_special && !s_zero && rnd;
            o_is_inexact       <= !s_special && !s_zero && (g | s);
            o_is_zero_result   <= !s_special && s_zero;
            o_result_sign      <= s_sign;
            o_rm               <= s_rm;
            o_is_special       <= s_special;
            o_special_result   <= s_sres;
            o_special_invalid  <= s_inv;
            o_special_div_zero <= s_dz;
            o_zero_sign        <= s_zs;
        end
    end
endmodule

// File: tb/tb_fp_normalize_round.sv
// tb_fp_normalize_round: scoreboard bench for fp_normalize_round against an arithmetic reference model
module tb_fp_normalize_round;
    logic clk = 1'b0;
    logic rst_n;
    logic i_valid, o_ready, i_flush, i_ready, o_valid;
    logic [47:0] i_mantissa_raw;
    logic signed [9:0] i_exp, o_exp_work;
    logic i_sign, i_is_special, i_special_invalid, i_special_div_zero, i_zero_sign;
    logic [2:0] i_rm, o_rm;
    logic [31:0] i_special_result, o_special_result;
    logic [23:0] o_mantissa_work;
    logic o_round_up, o_is_inexact, o_is_zero_result, o_result_sign, o_is_special;
    logic o_special_invalid, o_special_div_zero, o_zero_sign;

    typedef struct {
        logic [47:0] raw; logic [9:0] ex; logic sg; logic [2:0] rm;
        logic sp; logic [31:0] sr; logic inv; logic dz; logic zs;
    } op_t;
    typedef struct {
        logic [9:0] ex; logic [23:0] mant; logic ru; logic nx; logic zr; logic chk_ex;
        logic sg; logic [2:0] rm; logic sp; logic [31:0] sr; logic inv; logic dz; logic zs;
    } res_t;

    res_t q[$];
    res_t cur;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fp_normalize_round dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_flush(i_flush),
        .i_mantissa_raw(i_mantissa_raw), .i_exp(i_exp), .i_sign(i_sign), .i_rm(i_rm),
        .i_is_special(i_is_special), .i_special_result(i_special_result),
        .i_special_invalid(i_special_invalid), .i_special_div_zero(i_special_div_zero),
        .i_zero_sign(i_zero_sign), .o_valid(o_valid), .i_ready(i_ready),
        .o_exp_work(o_exp_work), .o_mantissa_work(o_mantissa_work), .o_round_up(o_round_up),
        .o_is_inexact(o_is_inexact), .o_is_zero_result(o_is_zero_result),
        .o_result_sign(o_result_sign), .o_rm(o_rm), .o_is_special(o_is_special),
        .o_special_result(o_special_result), .o_special_invalid(o_special_invalid),
        .o_special_div_zero(o_special_div_zero), .o_zero_sign(o_zero_sign)
    );

    function automatic res_t meta(input op_t o);
        res_t r;
        r.ex = '0; r.mant = '0; r.ru = 1'b0; r.nx = 1'b0; r.zr = 1'b0; r.chk_ex = 1'b1;
        r.sg = o.sg; r.rm = o.rm; r.sp = o.sp; r.sr = o.sr; r.inv = o.inv; r.dz = o.dz; r.zs = o.zs;
        return r;
    endfunction

    // Value = raw * 2^(ex-46); result keeps 24 significant bits at exponent max(e,1)
    function automatic res_t model(input op_t o);
        res_t r;
        logic [63:0] raw;
        int msb, e, k;
        logic g, s;
        r = meta(o);
        raw = 64'(o.raw);
        if (o.sp) return r;
        if (raw == 0) begin
            r.zr = 1'b1;
            r.chk_ex = 1'b0;
            return r;
        end
        msb = 0;
        for (int i = 0; i < 48; i++) if (raw[i]) msb = i;
        e = int'($signed(o.ex)) + msb - 46;
        if (e > 511) e = 511;
        if (e < -512) e = -512;
        k = msb - 23;
        if (e <= 0) k = k + 1 - e;
        else r.ex = 10'(e);
        r.mant = (k >= 48) ? 24'd0 : (k >= 0) ? 24'(raw >> k) : 24'(raw << -k);
        g = (k >= 1 && k <= 48) ? raw[k-1] : 1'b0;
        s = (k < 2) ? 1'b0 : (k - 1 >= 48) ? 1'b1 : ((raw & ((64'd1 << (k - 1)) - 1)) != 0);
        r.nx = g | s;
        case (o.rm)
            3'd1: r.ru = 1'b0;
            3'd2: r.ru = (g | s) & o.sg;
            3'd3: r.ru = (g | s) & ~o.sg;
            3'd4: r.ru = g;
            default: r.ru = g & (s | r.mant[0]);
        endcase
        return r;
    endfunction

    function automatic res_t want(input op_t o, input int ex, input logic [23:0] mant,
                                  input logic ru, input logic nx, input logic zr);
        res_t r;
        r = meta(o);
        r.ex = 10'(ex); r.mant = mant; r.ru = ru; r.nx = nx; r.zr = zr; r.chk_ex = !zr;
        return r;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        o.raw = r[47:0] >> $urandom_range(0, 48);
        if ($urandom_range(0, 11) == 0) o.raw = '0;
        o.ex = ($urandom_range(0, 7) == 0) ? 10'($urandom()) : 10'($urandom_range(0, 340)) - 10'd40;
        o.sg = 1'($urandom()); o.rm = 3'($urandom_range(0, 7)); o.sp = ($urandom_range(0, 15) == 0);
        o.sr = $urandom(); o.inv = 1'($urandom()); o.dz = 1'($urandom()); o.zs = 1'($urandom());
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic apply(input op_t o, input res_t r);
        i_mantissa_raw = o.raw; i_exp = o.ex; i_sign = o.sg; i_rm = o.rm; i_is_special = o.sp;
        i_special_result = o.sr; i_special_invalid = o.inv; i_special_div_zero = o.dz;
        i_zero_sign = o.zs; cur = r; i_valid = 1'b1;
    endtask

    task automatic tick(output bit acc);
        @(negedge clk);
        acc = i_valid && o_ready && !i_flush;
        if (i_flush) q.delete();
        else if (acc) q.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input op_t o, input res_t r);
        bit acc = 1'b0;
        apply(o, r);
        for (int n = 0; n < 100 && !acc; n++) tick(acc);
        check("send_accept", 128'(acc), 128'(1));
    endtask

    task automatic dir(input logic [47:0] raw, input int ex, input logic sg, input logic [2:0] rm,
                       input int eex, input logic [23:0] emant, input logic eru, input logic enx);
        op_t o;
        o.raw = raw; o.ex = 10'(ex); o.sg = sg; o.rm = rm; o.sp = 1'b0;
        o.sr = $urandom(); o.inv = 1'b0; o.dz = 1'b0; o.zs = sg;
        send(o, want(o, eex, emant, eru, enx, 1'b0));
    endtask

    task automatic drain();
        bit acc;
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int n = 0; n < 60 && (q.size() != 0 || o_valid); n++) tick(acc);
        check("drain_empty", 128'(q.size()), 128'(0));
    endtask

    logic held;
    logic [76:0] last;

    function automatic logic [76:0] snap();
        return {o_exp_work, o_mantissa_work, o_round_up, o_is_inexact, o_is_zero_result,
                o_result_sign, o_rm, o_is_special, o_special_result, o_special_invalid,
                o_special_div_zero, o_zero_sign};
    endfunction

    initial begin : monitor
        res_t r;
        held = 1'b0;
        last = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) check("stall_hold", {o_valid, snap()}, {1'b1, last});
                if (o_valid && i_ready) begin
                    compared++;
                    if (q.size() == 0) begin
                        mismatched++;
                        $display("FAIL unexpected_output: got mant=%h with no result pending", o_mantissa_work);
                    end else begin
                        r = q.pop_front();
                        if ((r.chk_ex && o_exp_work !== r.ex) || o_mantissa_work !== r.mant ||
                            o_round_up !== r.ru || o_is_inexact !== r.nx || o_is_zero_result !== r.zr ||
                            o_result_sign !== r.sg || o_rm !== r.rm || o_is_special !== r.sp ||
                            o_special_result !== r.sr || o_special_invalid !== r.inv ||
                            o_special_div_zero !== r.dz || o_zero_sign !== r.zs) begin
                            mismatched++;
                            $display("FAIL result: got ex=%0d mant=%h ru=%b nx=%b zr=%b sg=%b rm=%0d sp=%b sr=%h inv=%b dz=%b zs=%b; expected ex=%0d(chk=%b) mant=%h ru=%b nx=%b zr=%b sg=%b rm=%0d sp=%b sr=%h inv=%b dz=%b zs=%b",
                                     o_exp_work, o_mantissa_work, o_round_up, o_is_inexact, o_is_zero_result,
                                     o_result_sign, o_rm, o_is_special, o_special_result, o_special_invalid,
                                     o_special_div_zero, o_zero_sign, $signed(r.ex), r.chk_ex, r.mant, r.ru,
                                     r.nx, r.zr, r.sg, r.rm, r.sp, r.sr, r.inv, r.dz, r.zs);
                        end
                    end
                end
                held = o_valid && !i_ready && !i_flush;
                last = snap();
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    initial begin : main
        op_t o;
        bit acc;
        rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        i_mantissa_raw = '0; i_exp = '0; i_sign = 1'b0; i_rm = '0; i_is_special = 1'b0;
        i_special_result = '0; i_special_invalid = 1'b0; i_special_div_zero = 1'b0; i_zero_sign = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 128'(o_valid), 128'(0));
        check("reset_ready", 128'(o_ready), 128'(1));
        check("reset_data", 128'(snap()), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        dir(48'h4000_0000_0000, 127, 1'b0, 3'd0, 127, 24'h800000, 1'b0, 1'b0);
        i_valid = 1'b0;
        @(negedge clk);
        check("latency_cycle1_valid", 128'(o_valid), 128'(0));
        @(negedge clk);
        check("latency_cycle2_valid", 128'(o_valid), 128'(1));
        @(posedge clk);
        #1;

        dir(48'h4000_0040_0000, 127, 1'b0, 3'd0, 127, 24'h800000, 1'b0, 1'b1);
        dir(48'h4000_00C0_0000, 127, 1'b0, 3'd0, 127, 24'h800001, 1'b1, 1'b1);
        dir(48'h4000_00C0_0000, 127, 1'b0, 3'd7, 127, 24'h800001, 1'b1, 1'b1);
        dir(48'h8000_0000_0000, 10, 1'b0, 3'd0, 11, 24'h800000, 1'b0, 1'b0);
        dir(48'h8000_0000_0000, 511, 1'b0, 3'd0, 511, 24'h800000, 1'b0, 1'b0);
        dir(48'h4000_0000_0000, -2, 1'b0, 3'd0, 0, 24'h100000, 1'b0, 1'b0);
        dir(48'h4000_0000_0000, 0, 1'b0, 3'd0, 0, 24'h400000, 1'b0, 1'b0);
        dir(48'h4000_0000_0000, 1, 1'b0, 3'd0, 1, 24'h800000, 1'b0, 1'b0);
        dir(48'h4000_0000_0000, -100, 1'b0, 3'd3, 0, 24'h000000, 1'b1, 1'b1);
        dir(48'h4000_0000_0001, 127, 1'b1, 3'd2, 127, 24'h800000, 1'b1, 1'b1);
        dir(48'h4000_0000_0001, 127, 1'b1, 3'd3, 127, 24'h800000, 1'b0, 1'b1);
        dir(48'h4000_0000_0001, 127, 1'b1, 3'd1, 127, 24'h800000, 1'b0, 1'b1);
        dir(48'h4000_0000_0001, 127, 1'b1, 3'd4, 127, 24'h800000, 1'b0, 1'b1);
        o.raw = '0; o.ex = 10'd50; o.sg = 1'b1; o.rm = 3'd0; o.sp = 1'b0;
        o.sr = 32'h0; o.inv = 1'b0; o.dz = 1'b0; o.zs = 1'b1;
        send(o, want(o, 0, 24'h0, 1'b0, 1'b0, 1'b1));
        o.raw = 48'h0123_4567_89AB; o.ex = 10'd5; o.sp = 1'b1;
        o.sr = 32'h7FC0_0000; o.inv = 1'b1; o.dz = 1'b1; o.zs = 1'b0;
        send(o, want(o, 0, 24'h0, 1'b0, 1'b0, 1'b0));
        drain();

        i_ready = 1'b0;
        o = rand_op(); apply(o, model(o)); tick(acc);
        check("stall_accept1", 128'(acc), 128'(1));
        o = rand_op(); apply(o, model(o)); tick(acc);
        check("stall_accept2", 128'(acc), 128'(1));
        o = rand_op(); apply(o, model(o)); tick(acc);
        check("stall_ready_low", 128'(acc), 128'(0));
        repeat (3) tick(acc);
        i_ready = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 10 && !acc; n++) tick(acc);
        check("stall_third_accept", 128'(acc), 128'(1));
        drain();

        for (int n = 1; n <= 2; n++) begin
            i_ready = 1'b0;
            for (int m = 0; m < n; m++) begin
                o = rand_op(); apply(o, model(o)); tick(acc);
            end
            o = rand_op(); apply(o, model(o));
            i_flush = 1'b1;
            tick(acc);
            i_flush = 1'b0;
            i_valid = 1'b0;
            @(negedge clk);
            check("flush_valid", 128'(o_valid), 128'(0));
            @(posedge clk);
            #1;
            i_ready = 1'b1;
            repeat (4) tick(acc);
            check("flush_nothing_out", 128'(o_valid), 128'(0));
        end

        acc = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (acc || !i_valid) begin
                o = rand_op();
                apply(o, model(o));
                i_valid = ($urandom_range(0, 3) != 0);
            end
            i_ready = ($urandom_range(0, 9) < 7);
            tick(acc);
            if (c == 400) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("async_reset_valid", 128'(o_valid), 128'(0));
                check("async_reset_ready", 128'(o_ready), 128'(1));
                check("async_reset_data", 128'(snap()), 128'(0));
                q.delete();
                i_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                acc = 1'b1;
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fp_normalize_round.md
# fp_normalize_round

Pipelined normalize-and-round-decision stage sitting directly upstream of `fp_result_assembler` in the FPU execute path. It accepts an unnormalized raw mantissa, exponent and sign from an arithmetic datapath (adder, multiplier, divider, sqrt, FMA). It produces the normalized `exp_work`, `mantissa_work`, `round_up` and `is_inexact` operands the assembler consumes, with subnormal denormalization applied. Special and zero metadata are carried alongside under a valid/ready handshake, so the arithmetic units share one normalization pipeline.

## Interface
- `FP_WIDTH`, 32, result width (passed-through special result)
- `ExpBits`, 8, exponent field bits
- `FracBits`, 23, fraction bits
- `MantBits`, 24, FracBits+1
- `ExpExtBits`, 10, signed working exponent width
- `RawBits`, 48, raw mantissa width; bit RawBits-2 has weight 2^0, bit RawBits-1 has weight 2^1 (carry)

Ports:
- `i_clk` in 1: clock; single clock domain
- `i_rst_n` in 1: reset, asynchronous and active-low
- `i_valid` in 1: upstream operation valid
- `o_ready` out 1: stage can accept
- `i_flush` in 1: kill all in-flight operations
- `i_mantissa_raw` in RawBits: unnormalized magnitude
- `i_exp` in ExpExtBits (signed): biased exponent of the 2^0 bit
- `i_sign`, `i_rm[2:0]`, `i_is_special`, `i_special_result[FP_WIDTH]`, `i_special_invalid`, `i_special_div_zero`, `i_zero_sign`: metadata, passed through aligned
- `o_valid` out 1: outputs valid
- `i_ready` in 1: downstream accepts
- `o_exp_work` out ExpExtBits (signed), `o_mantissa_work` out MantBits, `o_round_up` out 1, `o_is_inexact` out 1, `o_is_zero_result` out 1, plus registered copies of all metadata (`o_result_sign`, `o_rm`, `o_is_special`, `o_special_result`, `o_special_invalid`, `o_special_div_zero`, `o_zero_sign`)

## Operation
- Stage 1 (capture): registers inputs and a leading-zero count `lzc` of `i_mantissa_raw`, plus `raw_zero = (i_mantissa_raw == 0)`.
- Stage 2, normalize:
  - left shift by `lzc` so the MSB lands at bit RawBits-1
  - `e = i_exp + 1 - lzc`, computed at ExpExtBits+1 signed and saturated to ExpExtBits range
- Stage 2, denormalize when `e <= 0`:
  - right shift by `1 - e`, clamped to MantBits+2; every bit shifted out ORs into sticky
  - `o_exp_work = 0`
- Otherwise `o_exp_work = e`.
- Extraction:
  - `o_mantissa_work` = top MantBits bits
  - guard `g` = next bit
  - sticky `s` = OR of all remaining bits
- Inexact: `o_is_inexact = g | s`.
- Rounding, by `rm`:
  - RNE: `g & (s | lsb)`
  - RTZ: `0`
  - RDN: `(g|s) & sign`
  - RUP: `(g|s) & ~sign`
  - RMM: `g`
  - reserved encodings behave as RNE
- Zero: `raw_zero` with `!is_special` drives `o_is_zero_result = 1`, `o_round_up = 0`, `o_is_inexact = 0`.
- Special: when `is_special`, numeric outputs are don't-care but deterministic (zero); metadata passes through.

## Timing
- Latency: 2 cycles from `i_valid & o_ready` to `o_valid`. Throughput: 1 op/cycle.
- Handshake:
  - `adv2 = !v2 | i_ready`
  - `adv1 = !v1 | adv2`
  - `o_ready = adv1`, combinational from `i_ready` and the valid registers
- Stall: while `o_valid & !i_ready`, all outputs hold stable and in-flight ops are neither lost nor duplicated.
- Flush: `i_flush` clears `v1` and `v2` at the next edge. Flush has priority over a simultaneous capture, so an input accepted in a flush cycle is dropped.
- Reset: asynchronous assertion of `i_rst_n = 0` immediately drives `o_valid = 0`, all data outputs 0 and `o_ready = 1`. Ops in flight mid-operation are discarded. Release is synchronous to `i_clk`.
- Data registers load only on advance; there is no X-propagation when valid is low.

## Configuration
- `FP_NORM_ROUND_SINGLE_CYCLE_EN` defined: the stage-1 registers are removed, normalize and round are fully combinational into one output register, latency is 1, and `o_ready = !v2 | i_ready`.
- Undefined (default): 2-stage pipeline as above. Arithmetic results are identical in both modes.

## Test plan
- Basic normalize: 1.0 (bit 46 set), `exp=127`, RNE, with `i_ready=1` -> 2 cycles later `o_exp_work=127`, `o_mantissa_work=0x800000`, `o_round_up=0`, `o_is_inexact=0`.
- Ties, RNE, exp 127:
  - `i_mantissa_raw = 0x400000400000` (g=1, s=0, lsb=0) -> `o_mantissa_work=0x800000`, `round_up=0`, `nx=1`
  - `i_mantissa_raw = 0x400000C00000` (lsb=1) -> `o_mantissa_work=0x800001`, `round_up=1`
- Carry and subnormal: bit 47 set, `exp=10` -> `o_exp_work=11`. 1.0 with `exp=-2` -> `o_exp_work=0`, `o_mantissa_work=0x100000`, `nx=0`.
- Round modes: 1.0 plus bit 0 set, with `sign=1` -> RDN `round_up=1`, RUP `0`, RTZ `0`, RMM `0`, `nx=1` for all.
- Stall and flush: issue 3 back-to-back ops with `i_ready=0` -> `o_ready` falls after 2 accepts and outputs hold. Raising `i_ready` drains both in order. `i_flush` with 2 in flight -> `o_valid=0` the next cycle. An async reset pulse mid-stream -> `o_valid=0` immediately.
- Zero/special: `i_mantissa_raw=0` -> `o_is_zero_result=1`. `is_special=1`, `special_result=0x7FC00000` -> passed through unchanged with `invalid`/`dz` intact.
